// File: rtl/secded_pkg.sv
// ---------------------------------------------------------------------------
// secded_pkg
//  Shared definitions for the SECDED memory engine: FSM state encodings,
//  mode values, result-flag positions and the codeword bit-layout helpers.
//  No ports.
// ---------------------------------------------------------------------------
package secded_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_CALC = 3'd3;
   localparam logic [2:0] ST_WR   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_ENCODE = 1'b1;

   // Decode result flags sit in the two top bits of the result word.
   function automatic int ded_bit(input int cw);
      return cw - 1;
   endfunction

   function automatic int sec_bit(input int cw);
      return cw - 2;
   endfunction

   function automatic logic is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Code position of data bit j: data fills the non-power-of-two positions
   // from 3 upward, LSB first.
   function automatic int data_pos(input int j);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 3; p < 64; p++) begin
         if (!is_pow2(p)) begin
            if ((cnt == j) && (pos == 0)) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/secded_codec.sv
// ---------------------------------------------------------------------------
// secded_codec
//  Combinational Hamming SECDED encoder and decoder sharing one input word.
//  Ports:
//   i_word      CW   encode: data in [DATA_W-1:0]; decode: received codeword
//   o_enc_cw    CW   full codeword built from i_word[DATA_W-1:0]
//   o_dec_word  CW   {DED, SEC, zeros, data} decode result
//   o_sec       1    single error seen (and corrected)
//   o_ded       1    double error seen (data left uncorrected)
// ---------------------------------------------------------------------------
module secded_codec
   import secded_pkg::*;
#(
   parameter int PAR_W = 5
) (
   input  logic [2**(PAR_W-1)-1:0] i_word,
   output logic [2**(PAR_W-1)-1:0] o_enc_cw,
   output logic [2**(PAR_W-1)-1:0] o_dec_word,
   output logic                    o_sec,
   output logic                    o_ded
);

   localparam int CW     = 2**(PAR_W-1);
   localparam int DATA_W = CW - PAR_W;
   localparam int IW     = PAR_W - 1;

   logic [IW-1:0] w_enc_syn;
   logic [IW-1:0] w_syn;
   logic          w_q;
   logic [CW-1:0] w_fix;

   // The syndrome of a word is the XOR of the positions of its set bits, so
   // each Hamming parity bit is simply the matching bit of the data syndrome.
   always_comb begin
      w_enc_syn = '0;
      o_enc_cw  = '0;
      for (int j = 0; j < DATA_W; j++)
         o_enc_cw[IW'(data_pos(j))] = i_word[IW'(j)];
      for (int p = 1; p < CW; p++)
         if (o_enc_cw[IW'(p)]) w_enc_syn = w_enc_syn ^ IW'(p);
      for (int p = 1; p < CW; p++)
         if (is_pow2(p)) o_enc_cw[IW'(p)] = |(w_enc_syn & IW'(p));
      o_enc_cw[0] = ^o_enc_cw[CW-1:1];
   end

   always_comb begin
      w_syn = '0;
      for (int p = 1; p < CW; p++)
         if (i_word[IW'(p)]) w_syn = w_syn ^ IW'(p);
      w_q   = ^i_word;
      w_fix = i_word;
      // Odd overall parity means one flipped bit; syndrome 0 points at p0.
      if (w_q) w_fix[w_syn] = ~i_word[w_syn];
      o_sec = w_q;
      o_ded = !w_q && (w_syn != '0);
      o_dec_word = '0;
      for (int j = 0; j < DATA_W; j++)
         o_dec_word[IW'(j)] = w_fix[IW'(data_pos(j))];
      o_dec_word[IW'(ded_bit(CW))] = o_ded;
      o_dec_word[IW'(sec_bit(CW))] = o_sec;
   end

endmodule

// File: rtl/secded_mem_engine.sv
// ---------------------------------------------------------------------------
// secded_mem_engine
//  Walks N_WORDS codewords in a byte-wide memory, encoding or SECDED-decoding
//  each one and writing the result back, with SEC/DED event counters.
//  Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req, i_mode       start request (IDLE/DONE only), 0=decode 1=encode
//   o_done, o_busy      run complete / run in progress
//   o_mem_addr          byte address
//   o_mem_rd_en         read strobe, i_mem_rdata valid next cycle
//   i_mem_rdata         read data
//   o_mem_wr_en         write strobe, o_mem_wdata one byte per cycle
//   o_sec_cnt/o_ded_cnt saturating event counts of the last decode run
//
//  state | meaning
//  IDLE  | waiting for req after reset
//  RD    | issuing NB read strobes for the current word
//  CAP   | capturing the last returned byte
//  CALC  | registering codec result, first write strobe set up
//  WR    | issuing NB write strobes, low byte first
//  DONE  | run complete, done held until next req
// ---------------------------------------------------------------------------
module secded_mem_engine
   import secded_pkg::*;
#(
   parameter int PAR_W    = 5,
   parameter int N_WORDS  = 15,
   parameter int SRC_BASE = 30,
   parameter int DST_BASE = 0,
   parameter int ADDR_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic              i_mode,
   output logic              o_done,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd_en,
   input  logic [7:0]        i_mem_rdata,
   output logic              o_mem_wr_en,
   output logic [7:0]        o_mem_wdata,
   output logic [7:0]        o_sec_cnt,
   output logic [7:0]        o_ded_cnt
);

   localparam int CW = 2**(PAR_W-1);
   localparam int NB = CW / 8;
   localparam int BW = $clog2(NB);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
   localparam logic [7:0]    LAST_IDX  = 8'(N_WORDS - 1);

   logic [2:0]        r_state;
   logic [BW-1:0]     r_byte;
   logic [7:0]        r_idx;
   logic              r_mode;
   logic              r_done;
   logic [CW-1:0]     r_asm;
   logic [CW-1:0]     r_res;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic              r_rd_en;
   logic              r_wr_en;
   logic [7:0]        r_wdata;
   logic [7:0]        r_sec_cnt;
   logic [7:0]        r_ded_cnt;

   logic [CW-1:0]     w_enc_cw;
   logic [CW-1:0]     w_dec_word;
   logic [CW-1:0]     w_result;
   logic              w_sec;
   logic              w_ded;

   secded_codec #(.PAR_W(PAR_W)) u_codec (
      .i_word     (r_asm),
      .o_enc_cw   (w_enc_cw),
      .o_dec_word (w_dec_word),
      .o_sec      (w_sec),
      .o_ded      (w_ded)
   );

   assign w_result = (r_mode == MODE_ENCODE) ? w_enc_cw : w_dec_word;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_byte    <= '0;
         r_idx     <= '0;
         r_mode    <= MODE_DECODE;
         r_done    <= 1'b0;
         r_asm     <= '0;
         r_res     <= '0;
         r_addr    <= '0;
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_rd_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wdata   <= '0;
         r_sec_cnt <= '0;
         r_ded_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_req) begin
                  r_state   <= ST_RD;
                  r_mode    <= i_mode;
                  r_done    <= 1'b0;
                  r_sec_cnt <= '0;
                  r_ded_cnt <= '0;
                  r_idx     <= '0;
                  r_byte    <= '0;
                  r_addr    <= ADDR_W'(SRC_BASE);
                  r_dst_ptr <= ADDR_W'(DST_BASE);
                  r_rd_en   <= 1'b1;
               end
            end
            ST_RD: begin
               // Byte b arrives while strobe b+1 is out; the last one lands in CAP.
               if (r_byte != '0) r_asm <= {i_mem_rdata, r_asm[CW-1:8]};
               if (r_byte == LAST_BYTE) begin
                  r_state   <= ST_CAP;
                  r_rd_en   <= 1'b0;
                  r_src_ptr <= r_addr + 1'b1;
               end else begin
                  r_byte <= r_byte + 1'b1;
                  r_addr <= r_addr + 1'b1;
               end
            end
            ST_CAP: begin
               r_asm   <= {i_mem_rdata, r_asm[CW-1:8]};
               r_state <= ST_CALC;
            end
            ST_CALC: begin
               r_res   <= w_result >> 8;
               r_wdata <= w_result[7:0];
               r_wr_en <= 1'b1;
               r_addr  <= r_dst_ptr;
               r_byte  <= '0;
               r_state <= ST_WR;
               if (r_mode == MODE_DECODE) begin
                  if (w_sec && (r_sec_cnt != 8'hFF)) r_sec_cnt <= r_sec_cnt + 8'd1;
                  if (w_ded && (r_ded_cnt != 8'hFF)) r_ded_cnt <= r_ded_cnt + 8'd1;
               end
            end
            ST_WR: begin
               if (r_byte == LAST_BYTE) begin
                  r_wr_en   <= 1'b0;
                  r_dst_ptr <= r_addr + 1'b1;
                  if (r_idx == LAST_IDX) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 8'd1;
                     r_state <= ST_RD;
                     r_rd_en <= 1'b1;
                     r_addr  <= r_src_ptr;
                     r_byte  <= '0;
                  end
               end else begin
                  r_byte  <= r_byte + 1'b1;
                  r_addr  <= r_addr + 1'b1;
                  r_wdata <= r_res[7:0];
                  r_res   <= r_res >> 8;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_done      = r_done;
   assign o_busy      = (r_state == ST_RD) || (r_state == ST_CAP) ||
                        (r_state == ST_CALC) || (r_state == ST_WR);
   assign o_mem_addr  = r_addr;
   assign o_mem_rd_en = r_rd_en;
   assign o_mem_wr_en = r_wr_en;
   assign o_mem_wdata = r_wdata;
   assign o_sec_cnt   = r_sec_cnt;
   assign o_ded_cnt   = r_ded_cnt;

endmodule
